wr_ptr_ctrl: RTL and testbench
==============================

// Module: wr_ptr_ctrl
// PURPOSE
//  Write-domain pointer controller of the dual-clock FIFO; sits directly upstream of full_gen.
//  - Qualifies write requests and drives the FIFO memory write port.
//  - Keeps the binary/Gray write pointer; supplies the next Gray write pointer as full_gen ptr1.
//  - Synchronises the read-domain Gray read pointer into the write clock; supplies it as full_gen ptr2.
// PARAMETERS
//  DEPTH        8  pointer modulus, power of two, >=4; memory holds DEPTH/2 entries
//  SYNC_STAGES  2  flop stages in read-pointer synchroniser, >=2
// PORTS
//  clock          in   1              write-domain clock
//  resetn         in   1              synchronous active-low reset
//  push           in   1              write request
//  wdata_valid    out  1              push accepted this cycle (= memory write enable)
//  waddr          out  $clog2(DEPTH)-1  memory write address
//  full           in   1              registered full flag from full_gen
//  wptr_gray      out  $clog2(DEPTH)  registered Gray write pointer, to read-domain synchroniser
//  wptr_next_gray out  $clog2(DEPTH)  next Gray write pointer, to full_gen ptr1
//  rptr_gray_in   in   $clog2(DEPTH)  Gray read pointer, read clock domain (asynchronous)
//  rptr_sync      out  $clog2(DEPTH)  synchronised Gray read pointer, to full_gen ptr2
//  overflow       out  1              sticky overflow flag (WR_PTR_OVF_CHK_EN only)
// BEHAVIOUR
//  - Reset (resetn=0 at posedge clock): wbin=0, wptr_gray=0, all sync stages=0, overflow=0.
//    wptr_next_gray=0 and wdata_valid=0 while push=0.
//  - Accept: accept = push & ~full, combinational. wdata_valid = accept.
//  - waddr = wbin[$clog2(DEPTH)-2:0], i.e. wbin with its MSB dropped.
//  - wbin_next = wbin + accept, modulo DEPTH; wraps DEPTH-1 -> 0 with no special case.
//  - wptr_next_gray = wbin_next ^ (wbin_next >> 1), combinational.
//    full_gen registers full from this value, so full reflects the state after the current write.
//  - Each posedge: wbin <= wbin_next; wptr_gray <= wptr_next_gray.
//    wptr_gray is launched from a flop; no combinational Gray leaves the block toward the read domain.
//  - Sync chain: stage[0] <= rptr_gray_in; stage[i] <= stage[i-1]; rptr_sync = stage[SYNC_STAGES-1].
//    Latency is SYNC_STAGES write clocks.
//  - Push while full is ignored: no pointer move, no memory write.
//  - Full deasserts no earlier than SYNC_STAGES+1 write clocks after the read pointer advances.
//  - push held high: one accept per cycle until full; a write on the cycle full rises is still legal.
//  - Reset mid-operation clears pointers on the same edge, in-flight push included.
//    The read domain must be reset together with this block.
// CONFIGURATION
//  WR_PTR_OVF_CHK_EN defined:
//  - overflow <= 1 on any clock with push & full; stays 1 until resetn=0.
//  - Simulation assertion fires if wptr_next_gray changes by more than one bit per clock.
//  WR_PTR_OVF_CHK_EN undefined:
//  - overflow port present, tied 0; no assertion.
// TESTING  (DEPTH=8, SYNC_STAGES=2, full_gen attached)
//  1. Reset, rptr_gray_in=000, push=1 for 4 clocks:
//     - waddr 0,1,2,3; wptr_gray 001,011,010,110.
//     - full=1 one clock after 4th accept; wdata_valid=0 thereafter.
//  2. Hold full, push=1 for 3 more clocks:
//     - wbin stays 4, no wdata_valid.
//     - overflow=1 with EN, 0 without.
//  3. From full, rptr_gray_in 000->001:
//     - rptr_sync=001 after 2 clocks; full=0 on the next clock; next push accepted at waddr=0.
//  4. Wrap: 8 pushes interleaved with reads.
//     - wbin 7->0; wptr_gray 100->000; waddr returns to 0.
//     - Gray changes one bit per step throughout.
//  5. resetn=0 for one clock mid-burst with wbin=5:
//     - wbin, wptr_gray, rptr_sync=0 next clock; overflow cleared; next accept at waddr=0.
//  6. push=0 with random rptr_gray_in for 50 clocks:
//     - wbin constant; wdata_valid never asserts; rptr_sync tracks input with 2-clock lag.

Source files
------------

// File: rtl/wr_ptr_ctrl_if.sv
// wr_ptr_ctrl_if: write-side FIFO pointer bundle between wr_ptr_ctrl, the memory write port and full_gen
interface wr_ptr_ctrl_if #(parameter int DEPTH = 8);
  localparam int AW = $clog2(DEPTH);
  logic push;
  logic full;
  logic wdata_valid;
  logic overflow;
  logic [AW-2:0] waddr;
  logic [AW-1:0] wptr_gray;
  logic [AW-1:0] wptr_next_gray;
  logic [AW-1:0] rptr_gray_in;
  logic [AW-1:0] rptr_sync;
  modport master (
    input push, full, rptr_gray_in,
    output wdata_valid, waddr, wptr_gray, wptr_next_gray, rptr_sync, overflow
  );
  modport slave (
    output push, full, rptr_gray_in,
    input wdata_valid, waddr, wptr_gray, wptr_next_gray, rptr_sync, overflow
  );
endinterface

// File: rtl/wr_ptr_ctrl.sv
// wr_ptr_ctrl: write-domain pointer controller of the dual-clock FIFO (binary/Gray write pointer, read-pointer sync)
// Define WR_PTR_OVF_CHK_EN for the sticky overflow flag and the Gray single-step assertion.
module wr_ptr_ctrl #(
  parameter int DEPTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic clock,
  input logic resetn,
  wr_ptr_ctrl_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  logic accept;
  logic [AW-1:0] wbin, wbin_next, gray_next, gray_q;
  logic [AW-1:0] sync_q [SYNC_STAGES];
  always_comb begin
    accept = bus.push & ~bus.full;
    wbin_next = wbin + AW'(accept);
    gray_next = wbin_next ^ (wbin_next >> 1);
  end
  assign bus.wdata_valid = accept;
  assign bus.waddr = wbin[AW-2:0];
  assign bus.wptr_next_gray = gray_next;
  assign bus.wptr_gray = gray_q;
  assign bus.rptr_sync = sync_q[SYNC_STAGES-1];
  // The read pointer is asynchronous; only Gray-coded values cross, so each stage sees at most one bit in flight.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wbin <= '0;
      gray_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      wbin <= wbin_next;
      gray_q <= gray_next;
      sync_q[0] <= bus.rptr_gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
`ifdef WR_PTR_OVF_CHK_EN
  logic ovf_q, prev_ok;
  logic [AW-1:0] prev_gray;
  // prev_ok masks the first clock after reset, where the pointer legitimately jumps to zero.
  always_ff @(posedge clock) begin
    prev_gray <= gray_next;
    if (!resetn) begin
      ovf_q <= 1'b0;
      prev_ok <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (bus.push & bus.full);
      prev_ok <= 1'b1;
      if (prev_ok) assert ($countones(gray_next ^ prev_gray) <= 1);
    end
  end
  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// tb_wr_ptr_ctrl: directed bench for wr_ptr_ctrl with a behavioural full_gen attached
module tb_wr_ptr_ctrl;
  logic clock = 1'b0;
  logic resetn;
  int checks = 0;
  int failures = 0;
  int exp_wb;
  logic [2:0] last_rin;
  logic [2:0] v;
  logic [2:0] gt [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`ifdef WR_PTR_OVF_CHK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif
  wr_ptr_ctrl_if #(.DEPTH(8)) bus ();
  wr_ptr_ctrl #(.DEPTH(8), .SYNC_STAGES(2)) dut (.clock(clock), .resetn(resetn), .bus(bus));
  always #5 clock = ~clock;
  // full_gen: full when the next write pointer is DEPTH/2 ahead of the synchronised read pointer
  always_ff @(posedge clock)
    bus.full <= !resetn ? 1'b0 : (bus.wptr_next_gray == {~bus.rptr_sync[2:1], bus.rptr_sync[0]});
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask
  initial begin
    resetn = 1'b0;
    bus.push = 1'b0;
    bus.rptr_gray_in = 3'd0;
    tick();
    tick();
    resetn = 1'b1;
    check("rst_gray", 32'(bus.wptr_gray), 0);
    check("rst_next", 32'(bus.wptr_next_gray), 0);
    check("rst_valid", 32'(bus.wdata_valid), 0);
    check("rst_sync", 32'(bus.rptr_sync), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_waddr", 32'(bus.waddr), 0);
    // fill to full
    for (int i = 0; i < 4; i++) begin
      bus.push = 1'b1;
      #1;
      check("fill_waddr", 32'(bus.waddr), 32'(i));
      check("fill_valid", 32'(bus.wdata_valid), 1);
      check("fill_next", 32'(bus.wptr_next_gray), 32'(gt[i+1]));
      tick();
      check("fill_gray", 32'(bus.wptr_gray), 32'(gt[i+1]));
    end
    check("full_set", 32'(bus.full), 1);
    check("full_valid", 32'(bus.wdata_valid), 0);
    // push while full
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ovf_gray", 32'(bus.wptr_gray), 6);
      check("ovf_waddr", 32'(bus.waddr), 0);
      check("ovf_valid", 32'(bus.wdata_valid), 0);
    end
    check("ovf_flag", 32'(bus.overflow), 32'(OVF_EXP));
    // read pointer advances, full drops after sync + register
    bus.push = 1'b0;
    bus.rptr_gray_in = 3'b001;
    tick();
    check("sync_lag1", 32'(bus.rptr_sync), 0);
    tick();
    check("sync_lag2", 32'(bus.rptr_sync), 1);
    check("full_hold", 32'(bus.full), 1);
    tick();
    check("full_clr", 32'(bus.full), 0);
    bus.push = 1'b1;
    #1;
    check("resume_valid", 32'(bus.wdata_valid), 1);
    check("resume_waddr", 32'(bus.waddr), 0);
    tick();
    bus.push = 1'b0;
    check("resume_gray", 32'(bus.wptr_gray), 32'(gt[5]));
    // wrap: reader catches up before each write
    exp_wb = 5;
    for (int i = 0; i < 8; i++) begin
      bus.rptr_gray_in = gt[exp_wb];
      tick();
      tick();
      tick();
      check("wrap_nfull", 32'(bus.full), 0);
      bus.push = 1'b1;
      #1;
      check("wrap_waddr", 32'(bus.waddr), 32'(exp_wb % 4));
      check("wrap_valid", 32'(bus.wdata_valid), 1);
      check("wrap_next", 32'(bus.wptr_next_gray), 32'(gt[(exp_wb+1)%8]));
      tick();
      bus.push = 1'b0;
      exp_wb = (exp_wb + 1) % 8;
      check("wrap_gray", 32'(bus.wptr_gray), 32'(gt[exp_wb]));
    end
    // reset mid-burst at wbin=5
    bus.push = 1'b1;
    resetn = 1'b0;
    #1;
    check("mid_waddr", 32'(bus.waddr), 1);
    tick();
    check("mid_gray", 32'(bus.wptr_gray), 0);
    check("mid_sync", 32'(bus.rptr_sync), 0);
    check("mid_ovf", 32'(bus.overflow), 0);
    check("mid_waddr0", 32'(bus.waddr), 0);
    resetn = 1'b1;
    bus.rptr_gray_in = 3'd0;
    #1;
    check("post_valid", 32'(bus.wdata_valid), 1);
    check("post_waddr", 32'(bus.waddr), 0);
    tick();
    bus.push = 1'b0;
    check("post_gray", 32'(bus.wptr_gray), 1);
    // idle with random read pointer
    last_rin = 3'd0;
    for (int i = 0; i < 50; i++) begin
      v = 3'($urandom_range(0, 7));
      bus.rptr_gray_in = v;
      tick();
      check("idle_sync", 32'(bus.rptr_sync), 32'(last_rin));
      check("idle_valid", 32'(bus.wdata_valid), 0);
      check("idle_gray", 32'(bus.wptr_gray), 1);
      last_rin = v;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
